// File: rtl/dmem_rmw_bridge_pkg.sv
// Shared encodings for the data-memory bridge: access sizes, bridge states, response latencies.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD_WAIT = 2'd1,
      ST_RMW_WRITE = 2'd2
   } state_t;

   localparam int LAT_WORD_STORE = 1;
   localparam int LAT_LOAD       = 2;
   localparam int LAT_SUB_STORE  = 2;

   // The reserved size code 3 behaves as a word, so bit 1 alone identifies word accesses.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/dmem_rmw_bridge_lane_align.sv
// Combinational lane logic: load lane extract with sign/zero extension, and sub-word store merge.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merge_data
);

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
      return uns ? {24'h0, b} : {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
   endfunction

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

      if (i_size == SZ_BYTE)
         o_load_data = ext_byte(w_byte, i_unsigned);
      else if (i_size == SZ_HALF)
         o_load_data = ext_half(w_half, i_unsigned);
      else
         o_load_data = i_rdata;
   end

   // Half merges ignore addr[0]; the half lane is chosen by addr[1] only.
   always_comb begin
      o_merge_data = i_rdata;
      if (i_size == SZ_BYTE)
         o_merge_data[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      else if (i_size == SZ_HALF)
         o_merge_data[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      else
         o_merge_data = i_wdata;
   end

endmodule

// File: rtl/dmem_rmw_bridge.sv
// Core load/store port to single-port word-write SRAM bridge with sub-word read-modify-write.
// Optional misalignment trap: define DMEM_RMW_BRIDGE_MISALIGN_CHK_EN.
module dmem_rmw_bridge
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int SRAM_AW = 32
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic               i_req_we,
   input  logic [1:0]         i_req_size,
   input  logic               i_req_unsigned,
   input  logic [ADDR_W-1:0]  i_req_addr,
   input  logic [31:0]        i_req_wdata,
   output logic               o_rsp_valid,
   output logic [31:0]        o_rsp_rdata,
   output logic               o_rsp_err,
   output logic               o_sram_en,
   output logic               o_sram_we,
   output logic [SRAM_AW-1:0] o_sram_addr,
   output logic [31:0]        o_sram_wdata,
   input  logic [31:0]        i_sram_rdata
);

   state_t              r_state;
   state_t              w_state_nxt;

   logic [SRAM_AW-1:2]  r_addr_p1;
   logic [1:0]          r_addr_lo_p1;
   logic [1:0]          r_size_p1;
   logic                r_uns_p1;
   logic [31:0]         r_wdata_p1;

   logic                r_rsp_valid;
   logic [31:0]         r_rsp_rdata;
   logic                r_rsp_err;

   logic                w_accept;
   logic                w_misalign;
   logic                w_rsp_valid_nxt;
   logic [31:0]         w_rsp_rdata_nxt;
   logic                w_rsp_err_nxt;
   logic [31:0]         w_load_data;
   logic [31:0]         w_merge_data;

`ifdef DMEM_RMW_BRIDGE_MISALIGN_CHK_EN
   assign w_misalign = ((i_req_size == SZ_HALF) & i_req_addr[0]) |
                       (is_word(i_req_size) & (|i_req_addr[1:0]));
`else
   assign w_misalign = 1'b0;
`endif

   assign o_req_ready = (r_state == ST_IDLE) & ~reset;
   assign w_accept    = i_req_valid & o_req_ready;

   dmem_lane_align u_lane (
      .i_rdata      (i_sram_rdata),
      .i_addr_lo    (r_addr_lo_p1),
      .i_size       (r_size_p1),
      .i_unsigned   (r_uns_p1),
      .i_wdata      (r_wdata_p1),
      .o_load_data  (w_load_data),
      .o_merge_data (w_merge_data)
   );

   always_comb begin
      w_state_nxt     = r_state;
      o_sram_en       = 1'b0;
      o_sram_we       = 1'b0;
      o_sram_addr     = {i_req_addr[SRAM_AW-1:2], 2'b00};
      o_sram_wdata    = i_req_wdata;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_rdata_nxt = 32'h0;
      w_rsp_err_nxt   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_misalign) begin
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_err_nxt   = 1'b1;
               end else if (i_req_we && is_word(i_req_size)) begin
                  o_sram_en       = 1'b1;
                  o_sram_we       = 1'b1;
                  w_rsp_valid_nxt = 1'b1;
               end else begin
                  // Loads and sub-word stores both start with a word read.
                  o_sram_en   = 1'b1;
                  w_state_nxt = i_req_we ? ST_RMW_WRITE : ST_LOAD_WAIT;
               end
            end
         end
         ST_LOAD_WAIT: begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = w_load_data;
            w_state_nxt     = ST_IDLE;
         end
         ST_RMW_WRITE: begin
            o_sram_en       = 1'b1;
            o_sram_we       = 1'b1;
            o_sram_addr     = {r_addr_p1, 2'b00};
            o_sram_wdata    = w_merge_data;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // An access caught by reset must never reach the SRAM.
      if (reset) begin
         o_sram_en = 1'b0;
         o_sram_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   // Request capture stage: the core may drop req_* after the accept edge.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr_p1    <= i_req_addr[SRAM_AW-1:2];
         r_addr_lo_p1 <= i_req_addr[1:0];
         r_size_p1    <= i_req_size;
         r_uns_p1     <= i_req_unsigned;
         r_wdata_p1   <= i_req_wdata;
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_rmw_bridge.sv
// Self-checking bench for dmem_rmw_bridge: SRAM model, arithmetic reference model and response scoreboard.
module tb_dmem_rmw_bridge;

`ifdef DMEM_RMW_BRIDGE_MISALIGN_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req_valid, i_req_we, i_req_unsigned;
   logic [1:0]  i_req_size;
   logic [31:0] i_req_addr, i_req_wdata;
   logic        o_req_ready, o_rsp_valid, o_rsp_err;
   logic [31:0] o_rsp_rdata;
   logic        o_sram_en, o_sram_we;
   logic [31:0] o_sram_addr, o_sram_wdata;
   logic [31:0] sram_rdata;

   always #5 clk = ~clk;

   dmem_rmw_bridge #(.ADDR_W(32), .SRAM_AW(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_we       (i_req_we),
      .i_req_size     (i_req_size),
      .i_req_unsigned (i_req_unsigned),
      .i_req_addr     (i_req_addr),
      .i_req_wdata    (i_req_wdata),
      .o_rsp_valid    (o_rsp_valid),
      .o_rsp_rdata    (o_rsp_rdata),
      .o_rsp_err      (o_rsp_err),
      .o_sram_en      (o_sram_en),
      .o_sram_we      (o_sram_we),
      .o_sram_addr    (o_sram_addr),
      .o_sram_wdata   (o_sram_wdata),
      .i_sram_rdata   (sram_rdata)
   );

   // SRAM: one-cycle read latency, word write.
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (o_sram_en) begin
         if (o_sram_we) mem[o_sram_addr[11:2]] <= o_sram_wdata;
         sram_rdata <= mem[o_sram_addr[11:2]];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
      logic        has_lit;
      logic [31:0] lit;
   } exp_t;

   logic [31:0] ref_mem [0:1023];
   exp_t        expq[$];
   exp_t        ce;
   int          total = 0;
   int          bad = 0;
   bit          chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (o_req_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", {31'h0, o_req_ready}, 32'h1);
   endtask

   // Model: works from byte counts and shifts on a word-array image of memory.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic has_lit, input logic [31:0] lit);
      int          bytes, a_lo, sh, idx;
      logic        err;
      logic [31:0] word, mask, val;
      exp_t        e;
      @(negedge clk);
      wait_ready();
      i_req_valid    = 1'b1;
      i_req_we       = we;
      i_req_size     = size;
      i_req_unsigned = uns;
      i_req_addr     = addr;
      i_req_wdata    = wdata;

      bytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      a_lo  = int'(addr[1:0]);
      err   = CHK && ((a_lo % bytes) != 0);
      sh    = (a_lo / bytes) * bytes * 8;
      idx   = int'(addr[11:2]);
      word  = ref_mem[idx];
      mask  = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 32'd1);
      val   = (word >> sh) & mask;
      if (!uns && bytes < 4 && val[8 * bytes - 1]) val = val | ~mask;
      if (we && !err) ref_mem[idx] = (word & ~(mask << sh)) | ((wdata & mask) << sh);

      e.due     = cyc + ((err || (we && bytes == 4)) ? 1 : 2);
      e.rdata   = (we || err) ? 32'h0 : val;
      e.err     = err;
      e.has_lit = has_lit;
      e.lit     = lit;
      expq.push_back(e);

      #1;
      check("acc_sram_en", {31'h0, o_sram_en}, {31'h0, !err});
      check("acc_sram_we", {31'h0, o_sram_we}, {31'h0, (we && bytes == 4 && !err)});
      if (!err) check("acc_sram_addr", o_sram_addr, {addr[31:2], 2'b00});
      if (we && bytes == 4 && !err) check("acc_sram_wdata", o_sram_wdata, wdata);
   endtask

   task automatic idle();
      @(negedge clk);
      i_req_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         if (expq.size() > 0 && expq[0].due == cyc) begin
            ce = expq.pop_front();
            check("rsp_valid", {31'h0, o_rsp_valid}, 32'h1);
            check("rsp_rdata", o_rsp_rdata, ce.rdata);
            check("rsp_err", {31'h0, o_rsp_err}, {31'h0, ce.err});
            if (ce.has_lit) check("rsp_literal", o_rsp_rdata, ce.lit);
         end else begin
            check("rsp_quiet", {31'h0, o_rsp_valid}, 32'h0);
            if (expq.size() > 0 && expq[0].due < cyc) begin
               check("rsp_overdue", 32'h0, 32'h1);
               void'(expq.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset          = 1'b1;
      i_req_valid    = 1'b1;
      i_req_we       = 1'b0;
      i_req_size     = 2'd2;
      i_req_unsigned = 1'b0;
      i_req_addr     = 32'h100;
      i_req_wdata    = 32'h0;
      repeat (3) begin
         @(negedge clk);
         #1 check("reset_sram_en", {31'h0, o_sram_en}, 32'h0);
      end
      i_req_valid = 1'b0;
      reset       = 1'b0;
      #1;
      check("reset_ready", {31'h0, o_req_ready}, 32'h1);
      check("reset_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
      check("reset_rsp_rdata", o_rsp_rdata, 32'h0);
      check("reset_rsp_err", {31'h0, o_rsp_err}, 32'h0);
      chk_on = 1'b1;

      // Preload through word stores.
      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h8899AABB, 1'b0, 32'h0);
      issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344, 1'b0, 32'h0);

      // Loads with extension.
      issue(1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 1'b1, 32'hFFFFFF99);
      issue(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 1'b1, 32'h00000099);
      issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1'b1, 32'hFFFF8899);
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'h8899AABB);
      issue(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hFFFFAABB);
      issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b1, 32'h00000088);
      issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b1, 32'h8899AABB);

      // Sub-word stores.
      issue(1'b1, 2'd0, 1'b0, 32'h201, 32'hFFFFFFEE, 1'b0, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1, 32'h1122EE44);
      issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344, 1'b0, 32'h0);
      issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF, 1'b0, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1, 32'hBEEF3344);

      // Back-to-back word stores.
      for (int i = 0; i < 4; i++)
         issue(1'b1, 2'd2, 1'b0, 32'h300 + 32'(4 * i), 32'hA0000000 + 32'(i), 1'b0, 32'h0);
      idle();

      // Reset while the RMW write is pending.
      wait_ready();
      i_req_valid = 1'b1;
      i_req_we    = 1'b1;
      i_req_size  = 2'd0;
      i_req_addr  = 32'h201;
      i_req_wdata = 32'h55;
      @(negedge clk);
      i_req_valid = 1'b0;
      reset       = 1'b1;
      #1 check("rst_rmw_sram_en", {31'h0, o_sram_en}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1 check("rst_release_ready", {31'h0, o_req_ready}, 32'h1);

      // Misaligned accesses: trapped with the check, masked without.
      issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 1'b1, CHK ? 32'h0 : 32'h8899AABB);
      issue(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 1'b1, CHK ? 32'h0 : 32'h00008899);
      issue(1'b1, 2'd2, 1'b0, 32'h302, 32'h12345678, 1'b0, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 1'b1, CHK ? 32'hA0000000 : 32'h12345678);
      idle();

      n = 0;
      while (expq.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain", expq.size(), 32'h0);

      check("mem_100", mem[10'h040], 32'h8899AABB);
      check("mem_200", mem[10'h080], 32'hBEEF3344);
      check("mem_300", mem[10'h0C0], ref_mem[10'h0C0]);
      for (int i = 1; i < 4; i++)
         check("mem_30x", mem[10'h0C0 + i], 32'hA0000000 + 32'(i));
      check("mem_ref_100", mem[10'h040], ref_mem[10'h040]);
      check("mem_ref_200", mem[10'h080], ref_mem[10'h080]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_rmw_bridge.md
# dmem_rmw_bridge

Data-memory bridge between the single-cycle core's load/store port and a synchronous single-port data SRAM with one-cycle read latency and a word-only write enable. It performs load extraction with sign/zero extension and converts byte/half stores into a read-modify-write sequence. A valid/ready request port and a one-shot response pulse let the core stall while an access is in flight.

## Interface
- ADDR_W, 32, byte address width
- SRAM_AW, 32, width of sram_addr (always word-aligned, low 2 bits zero)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  core presents an access
- req_ready  out  1  bridge can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
- req_unsigned  in  1  zero-extend load result (ld.bu/ld.hu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  misaligned access flag (tied 0 without macro)
- sram_en  out  1  SRAM access this cycle
- sram_we  out  1  SRAM word write
- sram_addr  out  SRAM_AW  {addr[31:2], 2'b00}
- sram_wdata  out  32  full word to write
- sram_rdata  in  32  read data, valid cycle after a read enable

## Operation
- States: IDLE, LOAD_WAIT, RMW_WRITE. Request accepted on req_valid & req_ready.
- Accept cycle (IDLE): sram_en driven combinationally from the request. Load or sub-word store -> read, sram_we=0. Word store -> write req_wdata directly, sram_we=1.
- Request fields (addr[1:0], size, unsigned, wdata) latched on accept.
- Load: IDLE -> LOAD_WAIT; in LOAD_WAIT select lane from sram_rdata by latched addr[1:0] (byte: any offset; half: addr[1]), extend per unsigned, register into rsp_rdata; -> IDLE with rsp_valid.
- Sub-word store: IDLE -> RMW_WRITE; in RMW_WRITE sram_en=1, sram_we=1, sram_wdata = sram_rdata with addressed byte/half replaced by latched wdata[7:0]/[15:0]; -> IDLE with rsp_valid.
- Word store: IDLE -> IDLE, rsp_valid next cycle.
- rsp_valid registered, high exactly one cycle; no response backpressure. A new request may be accepted in the same cycle rsp_valid is high.
- Misalignment without macro: half ignores addr[0], word ignores addr[1:0]; access proceeds.
- sram_en forced 0 while reset is high.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready 1 first cycle after reset deasserts.
- Latency accept->rsp_valid: word store 1, load 2, byte/half store 2 cycles.
- Throughput: word stores back-to-back every cycle; loads/sub-word stores one per 2 cycles.
- Reset mid-operation (LOAD_WAIT or RMW_WRITE): access abandoned, no SRAM write issued, no rsp_valid.
- Inputs other than req_* ignored outside IDLE; req_* need not be held after accept.

## Configuration
- DMEM_RMW_BRIDGE_MISALIGN_CHK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 raises rsp_err with rsp_valid one cycle after accept, rsp_rdata 0, no SRAM access (sram_en 0 in accept cycle).
- Undefined: no check, rsp_err constant 0, low address bits masked as above.

## Structure
- Package dmem_pkg: req_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, latency constants.
- Sub-module dmem_lane_align: combinational load lane extract/extend and store merge, shared by LOAD_WAIT and RMW_WRITE paths.

## Test plan
- SRAM[0x100]=0x8899AABB; load byte signed addr 0x102 -> rsp_rdata 0xFFFFFF99 two cycles after accept; unsigned -> 0x00000099.
- Load half signed addr 0x102 -> 0xFFFF8899; word addr 0x100 -> 0x8899AABB.
- SRAM[0x200]=0x11223344; store byte 0xEE to 0x201 -> read then write 0x1122EE44, rsp_valid accept+2.
- Store half 0xBEEF to 0x202 -> SRAM 0xBEEF3344; four word stores on consecutive cycles -> rsp_valid each cycle, all written.
- Reset asserted in RMW_WRITE cycle -> sram_en 0, SRAM unchanged, no rsp_valid, req_ready 1 after release.
- With macro: word load at 0x101 -> rsp_err 1, rsp_valid at accept+1, no sram_en; without macro -> reads word 0x100.
